// File: rtl/rng_health_monitor_if.sv
// Sample handshake between the mid-square generator and its health monitor.
interface rng_health_monitor_if #(
  parameter int unsigned W = 16
);
  logic         sample_valid;
  logic [W-1:0] sample;
  logic         sample_ready;

  modport master (output sample_valid, output sample, input sample_ready);
  modport slave  (input sample_valid, input sample, output sample_ready);
endinterface

// File: rtl/rng_health_monitor.sv
// Runtime health checks on a mid-square RNG stream: sticky zero detect,
// streaming Brent cycle detection and a windowed monobit test.
module rng_health_monitor #(
  parameter int unsigned W          = 16,
  parameter int unsigned WIN_LOG2   = 8,
  parameter int unsigned ONES_LO    = 1792,
  parameter int unsigned ONES_HI    = 2304,
  parameter int unsigned MAX_P_LOG2 = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  rng_health_monitor_if.slave                 s_if,
  output logic                                zero_flag,
  output logic                                cycle_found,
  output logic [MAX_P_LOG2:0]                 cycle_len,
  output logic                                search_exhausted,
  output logic                                win_done,
  output logic [$clog2(W+1)+WIN_LOG2-1:0]     win_ones,
  output logic                                monobit_fail
);

  localparam int unsigned PW = MAX_P_LOG2 + 1;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned OW = CW + WIN_LOG2;
  localparam logic [PW-1:0] P_MAX = {1'b1, {MAX_P_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, SEARCH, FOUND, EXHAUSTED} state_t;

  state_t              r_state, w_state_nxt;
  logic [W-1:0]        r_tort, w_tort_nxt;
  logic [PW-1:0]       r_power, w_power_nxt;
  logic [PW-1:0]       r_lam, w_lam_nxt;
  logic [PW-1:0]       w_lam_inc;
  logic [PW-1:0]       w_len_nxt;
  logic                w_found_nxt;
  logic                w_exh_nxt;

  logic                w_accept;
  logic [CW-1:0]       w_pop;
  logic [OW-1:0]       w_win_sum;
  logic                w_win_bad;
  logic                w_win_last;
  logic [OW-1:0]       r_acc;
  logic [WIN_LOG2-1:0] r_cnt;

  // Ready tracks reset only; samples offered during clr are dropped.
  assign s_if.sample_ready = rst;
  assign w_accept   = s_if.sample_valid && s_if.sample_ready && !clr;
  assign w_lam_inc  = r_lam + PW'(1);
  assign w_win_sum  = r_acc + OW'(w_pop);
  assign w_win_last = &r_cnt;
  assign w_win_bad  = (32'(w_win_sum) < ONES_LO) || (32'(w_win_sum) > ONES_HI);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(W); i++) begin
      w_pop = w_pop + CW'(s_if.sample[i]);
    end
  end

  // Brent state register and result flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_tort           <= '0;
      r_power          <= '0;
      r_lam            <= '0;
      cycle_found      <= 1'b0;
      cycle_len        <= '0;
      search_exhausted <= 1'b0;
    end else if (clr) begin
      r_state          <= IDLE;
      r_tort           <= '0;
      r_power          <= '0;
      r_lam            <= '0;
      cycle_found      <= 1'b0;
      cycle_len        <= '0;
      search_exhausted <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_tort           <= w_tort_nxt;
      r_power          <= w_power_nxt;
      r_lam            <= w_lam_nxt;
      cycle_found      <= w_found_nxt;
      cycle_len        <= w_len_nxt;
      search_exhausted <= w_exh_nxt;
    end
  end

  // Brent next state: tortoise teleports to the hare each time lam reaches power
  always_comb begin
    w_state_nxt = r_state;
    w_tort_nxt  = r_tort;
    w_power_nxt = r_power;
    w_lam_nxt   = r_lam;
    w_found_nxt = cycle_found;
    w_len_nxt   = cycle_len;
    w_exh_nxt   = search_exhausted;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          w_tort_nxt  = s_if.sample;
          w_power_nxt = PW'(1);
          w_lam_nxt   = '0;
          w_state_nxt = SEARCH;
        end
        SEARCH: begin
          if (s_if.sample == r_tort) begin
            w_len_nxt   = w_lam_inc;
            w_found_nxt = 1'b1;
            w_state_nxt = FOUND;
          end else if (w_lam_inc == r_power) begin
            if (r_power == P_MAX) begin
              w_exh_nxt   = 1'b1;
              w_state_nxt = EXHAUSTED;
            end else begin
              w_tort_nxt  = s_if.sample;
              w_power_nxt = r_power << 1;
              w_lam_nxt   = '0;
            end
          end else begin
            w_lam_nxt = w_lam_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Zero detect and monobit window accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_flag    <= 1'b0;
      win_done     <= 1'b0;
      win_ones     <= '0;
      monobit_fail <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
    end else if (clr) begin
      zero_flag    <= 1'b0;
      win_done     <= 1'b0;
      win_ones     <= '0;
      monobit_fail <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
    end else begin
      win_done <= w_accept && w_win_last;
      if (w_accept) begin
        if (s_if.sample == '0) zero_flag <= 1'b1;
        if (w_win_last) begin
          win_ones <= w_win_sum;
          if (w_win_bad) monobit_fail <= 1'b1;
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_win_sum;
          r_cnt <= r_cnt + WIN_LOG2'(1);
        end
      end
    end
  end

endmodule
